ifu_idu_inst_queue: RTL
=======================

// Module: ifu_idu_inst_queue
// PURPOSE
//  Decoupling instruction queue between the fetch stage and the decode stage.
//  Buffers fetched {inst, pc, pcplus4, fetch error} tuples in a small FIFO.
//  Valid/ready handshakes on both sides, registered storage.
//  A flush discards all buffered entries on a control-flow redirect (branch, jump, trap).
// PARAMETERS
//  DATA_WIDTH  32  width of inst, pc and pcplus4 fields
//  DEPTH       2   number of entries; power of two, >= 2
//  CNT_W       $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rstn         in   1           reset, asynchronous, active-low
//  flush        in   1           redirect; drop all entries and the in-cycle push
//  in_valid     in   1           fetch side holds a valid instruction (Ivalid)
//  in_ready     out  1           queue can accept (drives fetch-side Dready)
//  in_inst      in   DATA_WIDTH  fetched instruction word
//  in_pc        in   DATA_WIDTH  PC of in_inst
//  in_pcplus4   in   DATA_WIDTH  in_pc + 4
//  in_err       in   1           fetch bus error (rresp != OKAY)
//  out_valid    out  1           head entry valid toward decode
//  out_ready    in   1           decode consumes head this cycle
//  out_inst     out  DATA_WIDTH  head instruction
//  out_pc       out  DATA_WIDTH  head PC
//  out_pcplus4  out  DATA_WIDTH  head PC+4
//  out_err      out  1           head fetch-error flag
//  count        out  CNT_W       current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rstn=0, async): wptr=rptr=0, count=0, all storage=0.
//    Output values during and after reset: out_valid=0, out_* data=0, in_ready=1.
//  - push = in_valid & in_ready
//  - pop  = out_valid & out_ready
//  - in_ready  = (count != DEPTH) & ~flush
//    No combinational path from out_ready to in_ready. A full queue never accepts,
//    even when the head is being popped in the same cycle.
//  - out_valid = (count != 0) & ~flush
//  - out_* data = storage[rptr]. Purely a mux on registered state; 0 when empty
//    after reset, otherwise stale contents when empty.
//  - Latency: a push into an empty queue is visible on out_* in the next cycle.
//    There is no same-cycle bypass.
//  - push only: storage[wptr] <= in tuple; wptr <= wptr+1 mod DEPTH; count+1.
//  - pop only: rptr <= rptr+1 mod DEPTH; count-1.
//  - push & pop together (1 <= count < DEPTH): both pointers advance; count unchanged.
//  - Pointers wrap modulo DEPTH; count is the sole full/empty indicator.
//  - Flush: next edge sets wptr=rptr=0 and count=0. Both handshakes are masked in
//    the flush cycle, so no entry is accepted or consumed. Storage is not cleared.
//  - Flush held for multiple cycles: queue stays empty, in_ready=0, out_valid=0.
//  - Flush while rstn=0: reset dominates.
//  - Inputs sampled only when push=1. in_* may change freely while in_ready=0.
//  - in_err is carried through unchanged. The queue does not interpret it.
//  - Upstream must hold in_* stable while in_valid=1 & in_ready=0 (AXI-style).
//    Downstream may deassert out_ready at any time.
//  - count never exceeds DEPTH or underflows 0. Assert both in simulation.
// TESTING
//  - Reset: rstn=0 mid-traffic with count=2.
//    -> Same cycle: out_valid=0, count=0, in_ready=1. Held until rstn=1.
//  - Single pass: push inst=0x00000013, pc=0x80000000 while out_ready=0.
//    -> Next cycle: out_valid=1, out_pc=0x80000000, out_pcplus4=0x80000004, count=1.
//  - Fill/backpressure: out_ready=0, push pc 0x80000000 then 0x80000004.
//    -> count=2, in_ready=0. A third in_valid is not accepted.
//    -> Head stays at 0x80000000.
//  - Streaming: in_valid=1 & out_ready=1 for 10 cycles, pc incrementing by 4.
//    -> One instruction out per cycle after 1-cycle latency.
//    -> Order preserved across pointer wrap; count steady at 1.
//  - Flush: count=2, then flush=1 with in_valid=1 in the same cycle.
//    -> in_ready=0, out_valid=0. Next cycle count=0.
//    -> The next push (pc=0x80000100) is the next out_pc.
//  - Error tag: push with in_err=1 at pc=0x80000008.
//    -> Appears with out_err=1 at that PC only; neighbouring entries have out_err=0.

Source files
------------

// File: rtl/ifu_idu_inst_queue.sv
// ifu_idu_inst_queue: fetch-to-decode decoupling FIFO of {inst, pc, pcplus4, err} tuples
// with valid/ready handshakes on both sides and a flush that drops everything buffered.
module ifu_idu_inst_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_pcplus4,
    input  logic                  in_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_pcplus4,
    output logic                  out_err,
    output logic [CNT_W-1:0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcplus4;
        logic                  err;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr, rptr;
    logic          push, pop;

    // Ready depends only on registered occupancy, so a full queue never accepts
    // even while its head drains in the same cycle.
    assign in_ready    = (count != FULL) & ~flush;
    assign out_valid   = (count != '0) & ~flush;
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign head        = mem[rptr];
    assign out_inst    = head.inst;
    assign out_pc      = head.pc;
    assign out_pcplus4 = head.pcplus4;
    assign out_err     = head.err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{inst: in_inst, pc: in_pc, pcplus4: in_pcplus4, err: in_err};
                wptr      <= PW'(wptr + 1'b1);
            end
            if (pop) rptr <= PW'(rptr + 1'b1);
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (count <= FULL);
            assert (!(pop && count == '0));
            assert (!(push && !pop && count == FULL));
        end
    end
endmodule
